// File: rtl/sap_control_sequencer.sv
// ----------------------------------------------------------------------------
// sap_control_sequencer
//
// Microcode sequencer for the SAP-U CPU. Steps each instruction through the
// T-states T0..T4. It decodes the opcode and the latched flags into the 16-bit
// control word that drives the load/enable pins of every bus register. This is
// the only block that decides who drives the shared W-bus in each step.
//
// Parameters
//   HALT_ON_ILLEGAL  1: an undefined opcode executes as HLT
//                    0: an undefined opcode executes as NOP
//
// Optional feature (macro SINGLE_STEP_EN)
//   When defined, adds the step_req input. The step advances only on a
//   registered rising edge of step_req while run=1.
//   When undefined, the step advances on every clock while run=1.
//
// Ports
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous reset, active low
//   run        in   1   1 = advance, 0 = hold step with ctrl forced to 0
//   step_req   in   1   single-step request (only with SINGLE_STEP_EN)
//   opcode     in   4   IR[7:4], used from T2 onward
//   carry_in   in   1   latched carry flag
//   zero_in    in   1   latched zero flag
//   ctrl       out  16  control word, combinational from state
//                       bit map: 15 HLT,14 MI,13 RI,12 RO,11 IO,10 II,9 AI,
//                       8 AO,7 EO,6 SU,5 BI,4 OI,3 CE,2 CO,1 J,0 FI
//   step       out  3   current T-state, 0..4
//   halted     out  1   CPU halted
//   instr_done out  1   high in the last step of each instruction
// ----------------------------------------------------------------------------
module sap_control_sequencer #(
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
`ifdef SINGLE_STEP_EN
    input  logic        step_req,
`endif
    input  logic [3:0]  opcode,
    input  logic        carry_in,
    input  logic        zero_in,
    output logic [15:0] ctrl,
    output logic [2:0]  step,
    output logic        halted,
    output logic        instr_done
);

    localparam logic [15:0] C_HLT = 16'h8000;
    localparam logic [15:0] C_MI  = 16'h4000;
    localparam logic [15:0] C_RI  = 16'h2000;
    localparam logic [15:0] C_RO  = 16'h1000;
    localparam logic [15:0] C_IO  = 16'h0800;
    localparam logic [15:0] C_II  = 16'h0400;
    localparam logic [15:0] C_AI  = 16'h0200;
    localparam logic [15:0] C_AO  = 16'h0100;
    localparam logic [15:0] C_EO  = 16'h0080;
    localparam logic [15:0] C_SU  = 16'h0040;
    localparam logic [15:0] C_BI  = 16'h0020;
    localparam logic [15:0] C_OI  = 16'h0010;
    localparam logic [15:0] C_CE  = 16'h0008;
    localparam logic [15:0] C_CO  = 16'h0004;
    localparam logic [15:0] C_J   = 16'h0002;
    localparam logic [15:0] C_FI  = 16'h0001;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic        active;
    logic        is_illegal;
    logic        halts;
    logic        at_last;
    logic [2:0]  last_step;
    logic [15:0] ucode;

`ifdef SINGLE_STEP_EN
    logic req_q, req_d;
    logic req_prev_q, req_prev_d;

    // The request is registered once and compared with its previous value.
    // The resulting one-cycle pulse gates both advance and output.
    always_comb begin
        req_d      = step_req;
        req_prev_d = req_q;
        active     = run & req_q & ~req_prev_q;
    end
`else
    always_comb begin
        active = run;
    end
`endif

    // Decode the opcode into sequence length and halting behaviour.
    always_comb begin
        is_illegal = (opcode >= 4'h9) && (opcode <= 4'hD);
        halts      = (opcode == 4'hF) || (is_illegal && (HALT_ON_ILLEGAL != 0));
        case (opcode)
            4'h1, 4'h4: last_step = 3'd3;
            4'h2, 4'h3: last_step = 3'd4;
            default:    last_step = 3'd2;
        endcase
        // ">=" guarantees the step can never run past T4, even if the opcode
        // changes mid-instruction.
        at_last = (step_q >= last_step);
    end

    // Micro-word for the current step. Only one of RO/IO/AO/EO/CO is set in
    // any entry, so the W-bus never has two drivers.
    always_comb begin
        ucode = '0;
        case (step_q)
            3'd0: ucode = C_CO | C_MI;
            3'd1: ucode = C_RO | C_II | C_CE;
            default: begin
                case (opcode)
                    4'h1: ucode = (step_q == 3'd2) ? (C_IO | C_MI) : (C_RO | C_AI);
                    4'h2, 4'h3: begin
                        if (step_q == 3'd2)
                            ucode = C_IO | C_MI;
                        else if (step_q == 3'd3)
                            ucode = C_RO | C_BI;
                        else
                            ucode = C_EO | C_AI | C_FI | ((opcode == 4'h3) ? C_SU : 16'h0000);
                    end
                    4'h4: ucode = (step_q == 3'd2) ? (C_IO | C_MI) : (C_AO | C_RI);
                    4'h5: ucode = C_IO | C_AI;
                    4'h6: ucode = C_IO | C_J;
                    4'h7: ucode = carry_in ? (C_IO | C_J) : 16'h0000;
                    4'h8: ucode = zero_in ? (C_IO | C_J) : 16'h0000;
                    4'hE: ucode = C_AO | C_OI;
                    4'hF: ucode = C_HLT;
                    default: ucode = halts ? C_HLT : 16'h0000;
                endcase
            end
        endcase
    end

    // State register. The reset is synchronous, so a reset mid-instruction or
    // while halted always restarts with a fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            step_q  <= 3'd0;
`ifdef SINGLE_STEP_EN
            req_q      <= 1'b0;
            req_prev_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
`ifdef SINGLE_STEP_EN
            req_q      <= req_d;
            req_prev_q <= req_prev_d;
`endif
        end
    end

    // Next-state logic. HALT is only left through reset.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (state_q == ST_RUN && active) begin
            if (at_last) begin
                step_d = 3'd0;
                if (halts)
                    state_d = ST_HALT;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // Output logic. Halt keeps HLT asserted regardless of run.
    always_comb begin
        ctrl       = '0;
        instr_done = 1'b0;
        if (!rst_n) begin
            ctrl       = '0;
            instr_done = 1'b0;
        end else if (state_q == ST_HALT) begin
            ctrl = C_HLT;
        end else if (active) begin
            ctrl       = ucode;
            instr_done = at_last;
        end
        step   = step_q;
        halted = (state_q == ST_HALT);
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_sap_control_sequencer
//
// Self-checking bench for sap_control_sequencer. Two instances share the same
// stimulus: one with HALT_ON_ILLEGAL=0 (index 0) and one with HALT_ON_ILLEGAL=1
// (index 1). A behavioural model built from per-opcode micro-word tables and
// instruction lengths predicts ctrl, step, halted and instr_done every cycle.
// ----------------------------------------------------------------------------
module tb_sap_control_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step_req;
    logic [3:0]  opcode;
    logic        carry_in;
    logic        zero_in;

    logic [15:0] ctrl_o   [2];
    logic [2:0]  step_o   [2];
    logic        halted_o [2];
    logic        done_o   [2];

    int tests_run;
    int tests_failed;

    // Model state
    logic [15:0] uc_tab [16][5];
    int          len_tab [16];
    int          m_step [2];
    bit          m_halt [2];
    bit          m_rq;
    bit          m_rp;

    sap_control_sequencer #(.HALT_ON_ILLEGAL(0)) u_dut_nop (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .opcode     (opcode),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .ctrl       (ctrl_o[0]),
        .step       (step_o[0]),
        .halted     (halted_o[0]),
        .instr_done (done_o[0])
    );

    sap_control_sequencer #(.HALT_ON_ILLEGAL(1)) u_dut_hlt (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
`ifdef SINGLE_STEP_EN
        .step_req   (step_req),
`endif
        .opcode     (opcode),
        .carry_in   (carry_in),
        .zero_in    (zero_in),
        .ctrl       (ctrl_o[1]),
        .step       (step_o[1]),
        .halted     (halted_o[1]),
        .instr_done (done_o[1])
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Builds the microcode table straight from the instruction listing.
    // Conditional jumps and undefined opcodes are resolved at lookup time.
    task automatic initTables();
        for (int op = 0; op < 16; op++) begin
            for (int t = 0; t < 5; t++)
                uc_tab[op][t] = 16'h0000;
            uc_tab[op][0] = 16'h4004;
            uc_tab[op][1] = 16'h1408;
            len_tab[op]   = 3;
        end
        uc_tab[1][2] = 16'h4800; uc_tab[1][3] = 16'h1200; len_tab[1] = 4;
        uc_tab[2][2] = 16'h4800; uc_tab[2][3] = 16'h1020; uc_tab[2][4] = 16'h0281; len_tab[2] = 5;
        uc_tab[3][2] = 16'h4800; uc_tab[3][3] = 16'h1020; uc_tab[3][4] = 16'h02C1; len_tab[3] = 5;
        uc_tab[4][2] = 16'h4800; uc_tab[4][3] = 16'h2100; len_tab[4] = 4;
        uc_tab[5][2] = 16'h0A00;
        uc_tab[6][2] = 16'h0802;
        uc_tab[14][2] = 16'h0110;
        uc_tab[15][2] = 16'h8000;
    endtask

    function automatic bit opHalts(int op, int dut);
        return (op == 15) || (dut == 1 && op >= 9 && op <= 13);
    endfunction

    function automatic logic [15:0] modelWord(int op, int t, logic c, logic z, int dut);
        if (t == 2 && op == 7)
            return c ? 16'h0802 : 16'h0000;
        if (t == 2 && op == 8)
            return z ? 16'h0802 : 16'h0000;
        if (t == 2 && op >= 9 && op <= 13)
            return opHalts(op, dut) ? 16'h8000 : 16'h0000;
        return uc_tab[op][t];
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed 0x%04h, expected 0x%04h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Drives one clock cycle of inputs, checks both instances against the
    // model, then advances the model to the state after the next rising edge.
    task automatic applyStimulus(input logic rn, input logic r, input logic [3:0] op,
                                 input logic c, input logic z);
        bit          act;
        logic [15:0] exp_ctrl;
        bit          exp_done;
        @(negedge clk);
        rst_n    = rn;
        run      = r;
        opcode   = op;
        carry_in = c;
        zero_in  = z;
        #1;
`ifdef SINGLE_STEP_EN
        act = r && m_rq && !m_rp;
`else
        act = r;
`endif
        for (int d = 0; d < 2; d++) begin
            exp_ctrl = 16'h0000;
            exp_done = 1'b0;
            if (rn && m_halt[d]) begin
                exp_ctrl = 16'h8000;
            end else if (rn && act) begin
                exp_ctrl = modelWord(int'(op), m_step[d], c, z, d);
                exp_done = (m_step[d] == len_tab[op] - 1);
            end
            checkOutput($sformatf("dut%0d.ctrl", d), ctrl_o[d], exp_ctrl);
            checkOutput($sformatf("dut%0d.instr_done", d), {15'd0, done_o[d]}, {15'd0, exp_done});
            checkOutput($sformatf("dut%0d.step", d), {13'd0, step_o[d]}, 16'(m_step[d]));
            checkOutput($sformatf("dut%0d.halted", d), {15'd0, halted_o[d]}, {15'd0, m_halt[d]});
            if (!rn) begin
                m_step[d] = 0;
                m_halt[d] = 1'b0;
            end else if (!m_halt[d] && act) begin
                if (exp_done) begin
                    m_step[d] = 0;
                    m_halt[d] = opHalts(int'(op), d);
                end else begin
                    m_step[d] = m_step[d] + 1;
                end
            end
        end
        if (!rn) begin
            m_rq = 1'b0;
            m_rp = 1'b0;
        end else begin
            m_rp = m_rq;
            m_rq = step_req;
        end
    endtask

    // Runs one instruction's worth of cycles (plus slack in single-step mode
    // so that every step actually gets a request edge).
    task automatic runInstr(input logic [3:0] op, input logic c, input logic z, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step_req = ~step_req;
            applyStimulus(1'b1, 1'b1, op, c, z);
        end
    endtask

    initial begin
        int mult;
        logic [3:0] rop;
        tests_run    = 0;
        tests_failed = 0;
        step_req     = 1'b0;
        rst_n        = 1'b0;
        run          = 1'b0;
        opcode       = 4'h0;
        carry_in     = 1'b0;
        zero_in      = 1'b0;
        m_step       = '{0, 0};
        m_halt       = '{1'b0, 1'b0};
        m_rq         = 1'b0;
        m_rp         = 1'b0;
        initTables();
`ifdef SINGLE_STEP_EN
        mult = 2;
`else
        mult = 1;
`endif
        // The first cycle's register contents are unknown, so it is driven
        // without checking; the model starts from the post-reset state.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);

        // Directed instruction sequences.
        runInstr(4'h1, 1'b0, 1'b0, 4 * mult);
        runInstr(4'h3, 1'b0, 1'b0, 5 * mult);
        runInstr(4'h7, 1'b0, 1'b0, 3 * mult);
        runInstr(4'h7, 1'b1, 1'b0, 3 * mult);
        runInstr(4'h8, 1'b0, 1'b1, 3 * mult);
        runInstr(4'h4, 1'b0, 1'b0, 4 * mult);
        runInstr(4'h5, 1'b0, 1'b0, 3 * mult);
        runInstr(4'hE, 1'b0, 1'b0, 3 * mult);

        // ADD paused at T3, then resumed.
        runInstr(4'h2, 1'b0, 1'b0, 3 * mult);
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 1'b0, 4'h2, 1'b0, 1'b0);
        runInstr(4'h2, 1'b0, 1'b0, 2 * mult);

        // Undefined opcode: NOP on one instance, halt on the other.
        runInstr(4'hA, 1'b0, 1'b0, 3 * mult);
        runInstr(4'h0, 1'b0, 1'b0, 3 * mult);

        // HLT, then run toggling while halted, then reset and a fresh fetch.
        runInstr(4'hF, 1'b0, 1'b0, 3 * mult);
        for (int i = 0; i < 10; i++) begin
            step_req = ~step_req;
            applyStimulus(1'b1, logic'(i % 2), 4'h1, 1'b1, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        runInstr(4'h1, 1'b0, 1'b0, 4 * mult);

        // Randomized traffic. The opcode only changes between instructions.
        rop = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if (m_step[0] == 0 && m_step[1] == 0)
                rop = 4'($urandom_range(0, 15));
            step_req = 1'($urandom);
            applyStimulus(($urandom_range(0, 99) >= 2), ($urandom_range(0, 9) >= 2),
                          rop, 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
